mbr_scan_controller: RTL
========================

# mbr_scan_controller

Sequences the read-and-parse of the Master Boot Record for the storage path. On a start pulse it issues a single-sector read request to the block reader, consumes the returned 512-byte stream, and extracts the four partition start LBAs and type bytes. It validates the 0x55AA signature and publishes the results atomically to the Avalon debug/status register block and downstream filesystem logic.

## Interface
Parameters:
- SECTOR_LBA, 0, LBA requested for the MBR read.
- TIMEOUT_CYCLES, 1000000, watchdog limit in cycles; used only with MBR_SCAN_TIMEOUT_EN.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- io_start  in  1  scan request pulse; ignored unless idle.
- io_ReadReq_valid  out  1  sector read request.
- io_ReadReq_ready  in  1  block reader accepts request.
- io_ReadReq_lba  out  32  equals SECTOR_LBA.
- io_Data_valid  in  1  byte available.
- io_Data_bits  in  8  sector byte, offset 0 first.
- io_Data_ready  out  1  byte accepted when valid&ready.
- io_Partition1Start … io_Partition4Start  out  32 each  committed start LBAs.
- io_PartitionTypes  out  32  type bytes {P4,P3,P2,P1}.
- io_busy  out  1  scan in progress.
- io_done  out  1  one-cycle pulse on successful commit.
- io_error  out  1  sticky error flag.
- io_errorCode  out  2  0 none, 1 bad signature, 2 timeout.

## Operation
- States: IDLE, REQUEST, RECEIVE, CHECK.
- IDLE: io_start=1 → REQUEST; clears io_error/io_errorCode.
- REQUEST: io_ReadReq_valid=1, held until io_ReadReq_ready; the handshake cycle → RECEIVE, byte counter=0.
- RECEIVE: io_Data_ready=1; each accepted byte increments a 9-bit counter. Byte 511 accepted → CHECK.
- Entry i (0..3) base = 446+16·i. Offset +4 → shadow type[i]. Offsets +8..+11 → shadow start[i], little-endian (+8 is bits 7:0).
- Bytes 510 and 511 are captured into a signature shadow.
- CHECK: if signature == {0x55 at 510, 0xAA at 511}, copy shadows to outputs and pulse io_done. Otherwise set io_error, code 1, and leave outputs unchanged. Always → IDLE.
- io_Data_ready=0 outside RECEIVE. Bytes offered then are not consumed.
- io_busy=1 in REQUEST, RECEIVE, CHECK.
- io_start while busy is ignored; no queuing.
- Shadows are never visible at the outputs until CHECK commits. Outputs are never partially updated.

## Timing
- Reset: state IDLE. All outputs 0, including partition starts, types, error, code, done, busy, valid, ready. Counter 0.
- Reset mid-scan aborts immediately; previously committed values are cleared to 0.
- io_start at cycle t: io_ReadReq_valid=1 at t+1.
- Request accepted at cycle r: io_Data_ready=1 from r+1.
- Last byte accepted at cycle b: CHECK at b+1. Outputs and io_done valid at b+2, with io_busy=0 at b+2.
- Minimum scan with continuous data: 1 + request wait + 512 + 1 cycles.
- io_done is high exactly one cycle. io_error stays high until the next accepted io_start.
- io_start coincident with io_done (in IDLE at b+2) is accepted.

## Configuration
- MBR_SCAN_TIMEOUT_EN defined: a 32-bit counter runs while busy and resets on every request or byte handshake.
  - When the counter reaches TIMEOUT_CYCLES: → IDLE, io_error=1, io_errorCode=2, outputs unchanged, no io_done.
- MBR_SCAN_TIMEOUT_EN undefined: no watchdog. The scan waits indefinitely; io_errorCode never equals 2.

## Test plan
- Valid MBR: P1 start 0x00000800 type 0x0C, P2 0x00100000 type 0x83, P3/P4 zero, signature 55 AA → Partition1Start=0x00000800, Partition2Start=0x00100000, io_PartitionTypes=0x0000830C, one io_done pulse, io_error=0.
- Bad signature (byte 511=0xAB) after a prior good scan → outputs keep prior values, io_error=1, io_errorCode=1, no io_done; next good scan clears the error.
- Randomized io_Data_valid gaps and io_ReadReq_ready delayed 7 cycles → identical results to the first case; io_ReadReq_lba=SECTOR_LBA while valid; io_start pulses while busy are ignored.
- Reset asserted at byte 300 → next cycle all outputs 0, state IDLE; a fresh scan succeeds.
- Timeout (macro on, TIMEOUT_CYCLES=100): stall data after byte 10 → after 100 idle cycles io_error=1, io_errorCode=2, io_busy=0.
- Little-endian check: entry 4 bytes 8..11 = 01 02 03 04 → Partition4Start=0x04030201.

Source files
------------

// File: rtl/mbr_scan_controller.sv
// ---------------------------------------------------------------------------
// mbr_scan_controller
//
// Reads the Master Boot Record (one 512-byte sector) through the block
// reader, extracts the four partition start LBAs and type bytes, validates
// the 0x55AA boot signature and publishes the results atomically.
//
// Parameters
//   SECTOR_LBA      LBA requested for the MBR read.
//   TIMEOUT_CYCLES  watchdog limit in cycles (watchdog build only).
//
// Configuration
//   MBR_SCAN_TIMEOUT_EN  when defined, a watchdog aborts a stalled scan with
//                        io_errorCode = 2. Undefined: the scan waits forever.
//
// Ports
//   clock, reset          sole clock; synchronous active-high reset
//   io_start              scan request pulse, honoured only while idle
//   io_ReadReq_*          single-sector read request (valid/ready, lba)
//   io_Data_*             byte stream from the block reader, offset 0 first
//   io_Partition1..4Start committed partition start LBAs
//   io_PartitionTypes     committed type bytes {P4,P3,P2,P1}
//   io_busy               scan in progress
//   io_done               one-cycle pulse on a successful commit
//   io_error              sticky error flag, cleared by the next accepted start
//   io_errorCode          0 none, 1 bad signature, 2 timeout
// ---------------------------------------------------------------------------
module mbr_scan_controller #(
  parameter logic [31:0] SECTOR_LBA     = 32'd0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_start,
  output logic        io_ReadReq_valid,
  input  logic        io_ReadReq_ready,
  output logic [31:0] io_ReadReq_lba,
  input  logic        io_Data_valid,
  input  logic [7:0]  io_Data_bits,
  output logic        io_Data_ready,
  output logic [31:0] io_Partition1Start,
  output logic [31:0] io_Partition2Start,
  output logic [31:0] io_Partition3Start,
  output logic [31:0] io_Partition4Start,
  output logic [31:0] io_PartitionTypes,
  output logic        io_busy,
  output logic        io_done,
  output logic        io_error,
  output logic [1:0]  io_errorCode
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_RECEIVE,
    S_CHECK
  } state_t;

  localparam logic [8:0]  TABLE_FIRST = 9'd446;
  localparam logic [8:0]  SIG_LO      = 9'd510;
  localparam logic [8:0]  SIG_HI      = 9'd511;
  localparam logic [15:0] BOOT_SIG    = 16'h55AA;

  state_t state, state_nxt;

  logic [8:0]       byte_cnt;
  logic [3:0][7:0]  shd_type;
  logic [3:0][31:0] shd_start;
  logic [15:0]      shd_sig;

  logic       req_fire;
  logic       data_fire;
  logic       in_table;
  logic [5:0] table_rel;
  logic [1:0] table_ent;
  logic [3:0] table_off;
  logic       sig_ok;
  logic       timeout_hit;

  assign req_fire  = (state == S_REQUEST) && io_ReadReq_ready;
  assign data_fire = (state == S_RECEIVE) && io_Data_valid;

  // Partition table occupies offsets 446..509: four 16-byte entries.
  assign in_table  = (byte_cnt >= TABLE_FIRST) && (byte_cnt < SIG_LO);
  assign table_rel = 6'(byte_cnt - TABLE_FIRST);
  assign table_ent = table_rel[5:4];
  assign table_off = table_rel[3:0];

  // Byte 510 lands in the upper half, byte 511 in the lower half.
  assign sig_ok = (shd_sig == BOOT_SIG);

  assign io_ReadReq_lba = SECTOR_LBA;

`ifdef MBR_SCAN_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        wd_active;

  // CHECK lasts one cycle and always completes, so only the two waiting
  // states are guarded.
  assign wd_active = (state == S_REQUEST) || (state == S_RECEIVE);

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (!wd_active || req_fire || data_fire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

  // Fires on the cycle in which the stall count would reach the limit.
  assign timeout_hit = wd_active && !req_fire && !data_fire &&
                       (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt        = state;
    io_ReadReq_valid = 1'b0;
    io_Data_ready    = 1'b0;
    io_busy          = 1'b1;
    unique case (state)
      S_IDLE: begin
        io_busy = 1'b0;
        if (io_start) begin
          state_nxt = S_REQUEST;
        end
      end
      S_REQUEST: begin
        io_ReadReq_valid = 1'b1;
        if (timeout_hit) begin
          state_nxt = S_IDLE;
        end else if (io_ReadReq_ready) begin
          state_nxt = S_RECEIVE;
        end
      end
      S_RECEIVE: begin
        io_Data_ready = 1'b1;
        if (timeout_hit) begin
          state_nxt = S_IDLE;
        end else if (io_Data_valid && (byte_cnt == SIG_HI)) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        io_busy   = 1'b0;
      end
    endcase
  end

  // Byte counter and shadow capture
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt  <= '0;
      shd_type  <= '0;
      shd_start <= '0;
      shd_sig   <= '0;
    end else begin
      if (req_fire) begin
        byte_cnt <= '0;
      end else if (data_fire) begin
        byte_cnt <= byte_cnt + 9'd1;
        if (in_table) begin
          if (table_off == 4'd4) begin
            shd_type[table_ent] <= io_Data_bits;
          end
          // Offsets +8..+11 hold the start LBA, least significant byte first.
          if (table_off[3:2] == 2'b10) begin
            shd_start[table_ent][{table_off[1:0], 3'b000} +: 8] <= io_Data_bits;
          end
        end
        if (byte_cnt == SIG_LO) begin
          shd_sig[15:8] <= io_Data_bits;
        end
        if (byte_cnt == SIG_HI) begin
          shd_sig[7:0] <= io_Data_bits;
        end
      end
    end
  end

  // Committed outputs and status
  always_ff @(posedge clock) begin
    if (reset) begin
      io_Partition1Start <= '0;
      io_Partition2Start <= '0;
      io_Partition3Start <= '0;
      io_Partition4Start <= '0;
      io_PartitionTypes  <= '0;
      io_done            <= 1'b0;
      io_error           <= 1'b0;
      io_errorCode       <= '0;
    end else begin
      io_done <= 1'b0;
      if ((state == S_IDLE) && io_start) begin
        io_error     <= 1'b0;
        io_errorCode <= '0;
      end
      if (state == S_CHECK) begin
        if (sig_ok) begin
          io_Partition1Start <= shd_start[0];
          io_Partition2Start <= shd_start[1];
          io_Partition3Start <= shd_start[2];
          io_Partition4Start <= shd_start[3];
          io_PartitionTypes  <= shd_type;
          io_done            <= 1'b1;
        end else begin
          io_error     <= 1'b1;
          io_errorCode <= 2'd1;
        end
      end
      if (timeout_hit) begin
        io_error     <= 1'b1;
        io_errorCode <= 2'd2;
      end
    end
  end

endmodule
